idct8_chen_ts: RTL

- 8-point 1-D inverse DCT using Chen's butterfly factorisation. Companion of the forward dct8_chen_ts.
- Accepts one 8-coefficient vector per handshake and returns 8 spatial samples.
- Pipelined and fully stallable, with valid/ready on both sides.
- Used for the decode path and for forward/inverse round-trip checks in the DCT parameter sweep.

---
 rtl/idct8_chen_ts.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/idct8_chen_ts.sv
// 8-point 1-D inverse DCT (Chen butterflies): 4 register stages behind one global
// stall enable. Internals are full precision; results are rounded half up and saturated.
module idct8_chen_ts #(
  parameter int IN_W    = 32,
  parameter int CONST_W = 16,
  parameter int FRAC    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IN_W-1:0] in0,
  input  logic signed [IN_W-1:0] in1,
  input  logic signed [IN_W-1:0] in2,
  input  logic signed [IN_W-1:0] in3,
  input  logic signed [IN_W-1:0] in4,
  input  logic signed [IN_W-1:0] in5,
  input  logic signed [IN_W-1:0] in6,
  input  logic signed [IN_W-1:0] in7,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [IN_W-1:0] out0,
  output logic signed [IN_W-1:0] out1,
  output logic signed [IN_W-1:0] out2,
  output logic signed [IN_W-1:0] out3,
  output logic signed [IN_W-1:0] out4,
  output logic signed [IN_W-1:0] out5,
  output logic signed [IN_W-1:0] out6,
  output logic signed [IN_W-1:0] out7
);

  localparam int STAGES    = 4;
  localparam int PROD_FRAC = FRAC + CONST_W - 2;
  localparam int SHIFT     = PROD_FRAC - FRAC;
  localparam int PW        = IN_W + CONST_W;
  localparam int AW        = PW + 1;
  localparam int SW        = PW + 2;
  localparam int BW        = PW + 3;
  localparam int RW        = PW + 4;

  // s_0 = cos(4pi/16)/2, so every term reduces to cos(m*pi/16)/2 scaled to CONST_W-2 fraction bits
  localparam real SCALE = $itor(1 << (CONST_W - 2));
  localparam logic signed [CONST_W-1:0] K1 = CONST_W'($rtoi(0.4903926402016152 * SCALE + 0.5));
  localparam logic signed [CONST_W-1:0] K2 = CONST_W'($rtoi(0.4619397662556434 * SCALE + 0.5));
  localparam logic signed [CONST_W-1:0] K3 = CONST_W'($rtoi(0.4157348061512726 * SCALE + 0.5));
  localparam logic signed [CONST_W-1:0] K4 = CONST_W'($rtoi(0.3535533905932738 * SCALE + 0.5));
  localparam logic signed [CONST_W-1:0] K5 = CONST_W'($rtoi(0.2777851165098011 * SCALE + 0.5));
  localparam logic signed [CONST_W-1:0] K6 = CONST_W'($rtoi(0.1913417161825449 * SCALE + 0.5));
  localparam logic signed [CONST_W-1:0] K7 = CONST_W'($rtoi(0.0975451610080641 * SCALE + 0.5));

  // Odd-part matrix: row j gives o[j] over X1,X3,X5,X7 with signs folded in
  localparam logic signed [CONST_W-1:0] KO [4][4] = '{
    '{ K1,  K3,  K5,  K7},
    '{ K3, -K7, -K1, -K5},
    '{ K5, -K1,  K7,  K3},
    '{ K7, -K5,  K3, -K1}
  };

  localparam logic signed [RW-1:0] RND     = RW'(1) << (SHIFT - 1);
  localparam logic signed [RW-1:0] SAT_MAX = (RW'(1) << (IN_W - 1)) - RW'(1);
  localparam logic signed [RW-1:0] SAT_MIN = -SAT_MAX - RW'(1);

  function automatic logic signed [PW-1:0] mul(input logic signed [IN_W-1:0] x,
                                               input logic signed [CONST_W-1:0] k);
    return PW'(x) * PW'(k);
  endfunction

  logic                    adv;
  logic [STAGES:1]         vld_d, vld_q;
  logic [5:0][PW-1:0]      s1_pe_d, s1_pe_q;
  logic [3:0][3:0][PW-1:0] s1_po_d, s1_po_q;
  logic [3:0][SW-1:0]      s2_e_d, s2_e_q, s2_o_d, s2_o_q;
  logic [7:0][BW-1:0]      s3_x_d, s3_x_q;
  logic [7:0][IN_W-1:0]    out_d, out_q;
  logic signed [IN_W-1:0]  xo [4];

  assign adv      = !vld_q[STAGES] || out_ready;
  assign in_ready = adv;

  always_comb begin
    vld_d = {vld_q[STAGES-1:1], in_valid & adv};
  end

  // S1: even products (c4X0, c4X4, c2X2, c6X2, c2X6, c6X6) and the 4x4 odd products
  always_comb begin
    xo[0] = in1;
    xo[1] = in3;
    xo[2] = in5;
    xo[3] = in7;
    s1_pe_d[0] = mul(in0, K4);
    s1_pe_d[1] = mul(in4, K4);
    s1_pe_d[2] = mul(in2, K2);
    s1_pe_d[3] = mul(in2, K6);
    s1_pe_d[4] = mul(in6, K2);
    s1_pe_d[5] = mul(in6, K6);
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 4; i++)
        s1_po_d[j][i] = mul(xo[i], KO[j][i]);
  end

  // S2: even butterflies and odd adder trees
  always_comb begin
    logic signed [AW-1:0] a0, a1, b0, b1, oa, ob;
    a0 = AW'($signed(s1_pe_q[0])) + AW'($signed(s1_pe_q[1]));
    a1 = AW'($signed(s1_pe_q[0])) - AW'($signed(s1_pe_q[1]));
    b0 = AW'($signed(s1_pe_q[2])) + AW'($signed(s1_pe_q[5]));
    b1 = AW'($signed(s1_pe_q[3])) - AW'($signed(s1_pe_q[4]));
    s2_e_d[0] = SW'(a0) + SW'(b0);
    s2_e_d[1] = SW'(a1) + SW'(b1);
    s2_e_d[2] = SW'(a1) - SW'(b1);
    s2_e_d[3] = SW'(a0) - SW'(b0);
    oa = '0;
    ob = '0;
    for (int j = 0; j < 4; j++) begin
      oa = AW'($signed(s1_po_q[j][0])) + AW'($signed(s1_po_q[j][1]));
      ob = AW'($signed(s1_po_q[j][2])) + AW'($signed(s1_po_q[j][3]));
      s2_o_d[j] = SW'(oa) + SW'(ob);
    end
  end

  // S3: x[n] = e[n] + o[n], x[7-n] = e[n] - o[n]
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      s3_x_d[n]     = BW'($signed(s2_e_q[n])) + BW'($signed(s2_o_q[n]));
      s3_x_d[7 - n] = BW'($signed(s2_e_q[n])) - BW'($signed(s2_o_q[n]));
    end
  end

  // S4: round half up, then clamp to the output range
  always_comb begin
    logic signed [RW-1:0] r, sh;
    r  = '0;
    sh = '0;
    for (int n = 0; n < 8; n++) begin
      r  = RW'($signed(s3_x_q[n])) + RND;
      sh = r >>> SHIFT;
      if (sh > SAT_MAX)      out_d[n] = IN_W'(SAT_MAX);
      else if (sh < SAT_MIN) out_d[n] = IN_W'(SAT_MIN);
      else                   out_d[n] = IN_W'(sh);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      out_q <= '0;
    end else if (adv) begin
      vld_q <= vld_d;
      out_q <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_pe_q <= s1_pe_d;
      s1_po_q <= s1_po_d;
      s2_e_q  <= s2_e_d;
      s2_o_q  <= s2_o_d;
      s3_x_q  <= s3_x_d;
    end
  end

  assign out_valid = vld_q[STAGES];
  assign out0 = out_q[0];
  assign out1 = out_q[1];
  assign out2 = out_q[2];
  assign out3 = out_q[3];
  assign out4 = out_q[4];
  assign out5 = out_q[5];
  assign out6 = out_q[6];
  assign out7 = out_q[7];

endmodule
